// File: rtl/calc_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | calc_pkg : ASCII key codes, keypad key map and scanner state encoding.    |
// | Revision : 1.0                                                            |
// +----------------------------------------------------------------------------+
package calc_pkg;

  localparam logic [7:0] KEY_NONE     = 8'h00;
  localparam logic [7:0] ASCII_0      = 8'h30;
  localparam logic [7:0] ASCII_1      = 8'h31;
  localparam logic [7:0] ASCII_2      = 8'h32;
  localparam logic [7:0] ASCII_3      = 8'h33;
  localparam logic [7:0] ASCII_4      = 8'h34;
  localparam logic [7:0] ASCII_5      = 8'h35;
  localparam logic [7:0] ASCII_6      = 8'h36;
  localparam logic [7:0] ASCII_7      = 8'h37;
  localparam logic [7:0] ASCII_8      = 8'h38;
  localparam logic [7:0] ASCII_9      = 8'h39;
  localparam logic [7:0] ASCII_PLUS   = 8'h2B;
  localparam logic [7:0] ASCII_MINUS  = 8'h2D;
  localparam logic [7:0] ASCII_STAR   = 8'h2A;
  localparam logic [7:0] ASCII_EQUALS = 8'h3D;
  localparam logic [7:0] ASCII_CLEAR  = 8'h43;

  typedef enum logic [1:0] {
    S_SCAN     = 2'd0,
    S_DEBOUNCE = 2'd1,
    S_EMIT     = 2'd2,
    S_HOLD     = 2'd3
  } scan_state_e;

  function automatic logic [7:0] keymap(input logic [1:0] row, input logic [1:0] col);
    logic [7:0] ch;
    ch = KEY_NONE;
    case ({row, col})
      4'b00_00: ch = ASCII_1;
      4'b00_01: ch = ASCII_2;
      4'b00_10: ch = ASCII_3;
      4'b00_11: ch = ASCII_PLUS;
      4'b01_00: ch = ASCII_4;
      4'b01_01: ch = ASCII_5;
      4'b01_10: ch = ASCII_6;
      4'b01_11: ch = ASCII_MINUS;
      4'b10_00: ch = ASCII_7;
      4'b10_01: ch = ASCII_8;
      4'b10_10: ch = ASCII_9;
      4'b10_11: ch = ASCII_STAR;
      4'b11_00: ch = ASCII_CLEAR;
      4'b11_01: ch = ASCII_0;
      4'b11_10: ch = ASCII_EQUALS;
      default:  ch = KEY_NONE;
    endcase
    return ch;
  endfunction

  // Exactly one active-low row; none or several (ghosting) is treated as no press.
  function automatic logic single_low(input logic [3:0] rows);
    return (rows == 4'b1110) || (rows == 4'b1101) ||
           (rows == 4'b1011) || (rows == 4'b0111);
  endfunction

  function automatic logic [1:0] low_index(input logic [3:0] rows);
    logic [1:0] idx;
    idx = 2'd0;
    case (rows)
      4'b1101: idx = 2'd1;
      4'b1011: idx = 2'd2;
      4'b0111: idx = 2'd3;
      default: idx = 2'd0;
    endcase
    return idx;
  endfunction

endpackage
`default_nettype wire

// File: rtl/keypad_sync.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | keypad_sync : two-flop synchroniser for the 4 active-low keypad rows.     |
// | Revision    : 1.0                                                         |
// +----------------------------------------------------------------------------+
module keypad_sync (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] row_async_i,
  output logic [3:0] row_sync_o
);

  logic [3:0] meta_q;
  logic [3:0] sync_q;

  // Resets to all-ones so an idle (pulled-up) keypad is seen from the start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 4'b1111;
      sync_q <= 4'b1111;
    end else begin
      meta_q <= row_async_i;
      sync_q <= meta_q;
    end
  end

  assign row_sync_o = sync_q;

endmodule
`default_nettype wire

// File: rtl/keypad_scanner.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | keypad_scanner : 4x4 keypad column scan, debounce and ASCII key emit.     |
// | Revision       : 1.0                                                      |
// +----------------------------------------------------------------------------+
module keypad_scanner
  import calc_pkg::*;
#(
  parameter int SCAN_DIV       = 50000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] row_in,
  output logic [3:0] col_out,
  output logic       btn_valid,
  output logic [7:0] btn_char,
  output logic       key_held
);

  localparam int               DIV_W      = $clog2(SCAN_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(SCAN_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_ONE    = DIV_W'(1);
  localparam logic [3:0]       DEB_TARGET = 4'(DEBOUNCE_SCANS);

  logic [3:0]       row_s;
  logic             tick;
  logic [7:0]       emit_char;
  logic             same_row;
  logic [3:0]       cnt_inc;
  logic [3:0]       rel_inc;

  scan_state_e      state_q,   state_d;
  logic [DIV_W-1:0] div_q,     div_d;
  logic [1:0]       col_q,     col_d;
  logic [1:0]       row_idx_q, row_idx_d;
  logic [3:0]       cnt_q,     cnt_d;
  logic [3:0]       rel_q,     rel_d;
  logic [7:0]       char_q,    char_d;

  keypad_sync u_sync (
    .clk         (clk),
    .rst_n       (rst_n),
    .row_async_i (row_in),
    .row_sync_o  (row_s)
  );

  assign tick      = (div_q == DIV_LAST);
  assign emit_char = keymap(row_idx_q, col_q);
  assign same_row  = single_low(row_s) && (low_index(row_s) == row_idx_q);
  assign cnt_inc   = cnt_q + 4'd1;
  assign rel_inc   = rel_q + 4'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_SCAN;
      div_q     <= '0;
      col_q     <= 2'd0;
      row_idx_q <= 2'd0;
      cnt_q     <= 4'd0;
      rel_q     <= 4'd0;
      char_q    <= KEY_NONE;
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      col_q     <= col_d;
      row_idx_q <= row_idx_d;
      cnt_q     <= cnt_d;
      rel_q     <= rel_d;
      char_q    <= char_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    div_d     = tick ? '0 : div_q + DIV_ONE;
    col_d     = col_q;
    row_idx_d = row_idx_q;
    cnt_d     = cnt_q;
    rel_d     = rel_q;
    char_d    = char_q;
    case (state_q)
      S_SCAN: begin
        if (tick) begin
          if (single_low(row_s)) begin
            row_idx_d = low_index(row_s);
            cnt_d     = 4'd1;
            state_d   = S_DEBOUNCE;
          end else begin
            col_d = col_q + 2'd1;
          end
        end
      end
      S_DEBOUNCE: begin
        if (tick) begin
          if (same_row) begin
            if (cnt_inc == DEB_TARGET) begin
              state_d = S_EMIT;
              // Load the character on entry so it is already valid during the pulse.
              if (emit_char != KEY_NONE) begin
                char_d = emit_char;
              end
            end else begin
              cnt_d = cnt_inc;
            end
          end else begin
            col_d   = col_q + 2'd1;
            state_d = S_SCAN;
          end
        end
      end
      S_EMIT: begin
        rel_d   = 4'd0;
        state_d = S_HOLD;
      end
      S_HOLD: begin
        if (tick) begin
          if (row_s[row_idx_q]) begin
            if (rel_inc == DEB_TARGET) begin
              rel_d   = 4'd0;
              col_d   = col_q + 2'd1;
              state_d = S_SCAN;
            end else begin
              rel_d = rel_inc;
            end
          end else begin
            rel_d = 4'd0;
          end
        end
      end
      default: state_d = S_SCAN;
    endcase
  end

  always_comb begin
    col_out   = ~(4'b0001 << col_q);
    btn_valid = (state_q == S_EMIT) && (emit_char != KEY_NONE);
    key_held  = (state_q == S_EMIT) || (state_q == S_HOLD);
  end

  assign btn_char = char_q;

endmodule
`default_nettype wire
